data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

- Two-requester arbiter and sequencer in front of the single-port data memory (32-bit, 256 words, synchronous write, combinational read).
- Port 0 serves the core load/store path; port 1 serves the debug/DMA path.
- Grants one access per cycle with round-robin on contention, drives the memory's write_read/address/write_data, and returns registered read data or write acknowledgement per port under a valid/ready handshake with response backpressure.

## Interface
Parameters:
- WIDTH, 32, data and address width
- MEM_DEPTH, 256, number of memory words; addresses at or above MEM_DEPTH are out of range

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- p0_req_valid / p1_req_valid  in  1  request present
- p0_req_we / p1_req_we  in  1  1 = write, 0 = read
- p0_req_addr / p1_req_addr  in  WIDTH  word address
- p0_req_wdata / p1_req_wdata  in  WIDTH  write data
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle (combinational)
- p0_rsp_valid / p1_rsp_valid  out  1  response pending
- p0_rsp_rdata / p1_rsp_rdata  out  WIDTH  read data; 0 for writes and errors
- p0_rsp_err / p1_rsp_err  out  1  address out of range
- p0_rsp_ready / p1_rsp_ready  in  1  response consumed
- mem_write_read  out  1  memory write enable
- mem_address  out  WIDTH  memory address
- mem_write_data  out  WIDTH  memory write data
- mem_read_data  in  WIDTH  memory combinational read data

## Operation
- A port is eligible when req_valid=1 and its response slot is free: rsp_valid=0, or rsp_ready=1 in the same cycle.
- Exactly one eligible port is granted per cycle.
  - Only one port eligible: that port is granted.
  - Both eligible: the port not granted last is granted.
- Priority state is a 1-bit last_grant register, updated only on a grant.
  - Reset value is 1, so port 0 wins the first tie.
- The granted port sees req_ready=1 in the grant cycle; the other port sees req_ready=0.
- Memory drive in the grant cycle (combinational from the granted request):
  - mem_address = granted addr.
  - mem_write_data = granted wdata.
  - mem_write_read = we AND in_range.
- Memory drive with no grant, or while reset=0:
  - mem_write_read=0, mem_address=0, mem_write_data=0.
- Response capture at the end of the grant cycle, into the granted port's slot:
  - rsp_valid ← 1.
  - rsp_err ← !in_range.
  - rsp_rdata ← (read AND in_range) ? mem_read_data : 0.
- A slot clears (rsp_valid ← 0, rdata/err ← 0) when rsp_valid && rsp_ready and no new grant to that port occurs in the same cycle.
- Grant and consume in the same cycle: the slot is overwritten with the new response and rsp_valid stays 1.
- Out-of-range write: no memory write, err=1. Out-of-range read: rdata=0, err=1.
- in_range = addr < MEM_DEPTH, compared at full WIDTH.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - all rsp_valid/rsp_rdata/rsp_err = 0, last_grant = 1.
  - req_ready = 0 and mem_write_read = 0 while reset=0.
- Latency: request accepted in cycle N; memory written at the posedge ending N; rsp_valid=1 in cycle N+1.
- Throughput: one access per cycle total; one per cycle per port if the consumer holds rsp_ready=1.
- Ordering: an access granted in cycle N+1 observes a write granted in cycle N (read-after-write across ports is coherent).
- Reset asserted mid-cycle: any in-flight grant is dropped and the memory is not written; no response is produced after reset.
- Requesters hold valid/we/addr/wdata stable until req_ready; the arbiter does not register requests.

## Structure
- Shared package holds constants only: DMEM_WIDTH=32, DMEM_DEPTH=256, port index encodings PORT_CORE=0, PORT_DBG=1.
- One sub-module: dmem_rsp_slot, instantiated twice.
  - Contains the rsp_valid/rdata/err registers plus eligibility and clear logic.
  - Arbitration and memory muxing stay in the top.
- The top instantiates nothing else; the memory is connected at the next level up.

## Test plan
- Reset, then p0 writes 0xDEADBEEF to addr 5 → p0_req_ready=1 in the same cycle; p0_rsp_valid=1 next cycle with rdata=0, err=0; a subsequent p0 read of addr 5 returns 0xDEADBEEF.
- p0 and p1 both valid every cycle, rsp_ready=1 → grants alternate p0,p1,p0,p1; p0 wins the first tie after reset.
- p1 rsp_ready held 0 with a pending response, p1 keeps requesting → p1_req_ready stays 0 and p0 gets every grant; p1 resumes in the cycle its rsp_ready rises.
- p0 writes 0x12345678 to addr 10 in cycle N, p1 reads addr 10 in cycle N+1 → p1_rsp_rdata=0x12345678.
- p0 writes addr 256 → err=1 and the memory is unchanged; p1 reads addr 0xFFFF_FFFF → err=1, rdata=0.
- Reset pulled low during a granted write to addr 3 (old value 0x1) → mem_write_read drops immediately; addr 3 still reads 0x1 after reset; all rsp_valid=0.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: memory geometry and
// requester port index encodings.
package data_mem_arbiter_pkg;

    localparam int   DMEM_WIDTH = 32;
    localparam int   DMEM_DEPTH = 256;
    localparam logic PORT_CORE  = 1'b0;
    localparam logic PORT_DBG   = 1'b1;

endpackage : data_mem_arbiter_pkg

// File: rtl/dmem_rsp_slot.sv
// One-deep response slot for a single requester. It holds the registered
// response and reports whether this port can take a new grant this cycle.
module dmem_rsp_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_i,
    input  logic             rsp_ready_i,
    input  logic             grant_i,
    input  logic [WIDTH-1:0] cap_rdata_i,
    input  logic             cap_err_i,
    output logic             eligible_o,
    output logic             rsp_valid_o,
    output logic [WIDTH-1:0] rsp_rdata_o,
    output logic             rsp_err_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q,   err_d;

    // The slot frees up in the same cycle its response is consumed.
    assign eligible_o = req_valid_i && (!valid_q || rsp_ready_i);

    // Next-state: a new grant overwrites, otherwise a consumed response clears.
    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (grant_i) begin
            valid_d = 1'b1;
            rdata_d = cap_rdata_i;
            err_d   = cap_err_i;
        end else if (valid_q && rsp_ready_i) begin
            valid_d = 1'b0;
            rdata_d = '0;
            err_d   = 1'b0;
        end else begin
            valid_d = valid_q;
            rdata_d = rdata_q;
            err_d   = err_q;
        end
    end

    // Response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule : dmem_rsp_slot

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter between the core (port 0) and debug/DMA (port 1)
// requesters in front of a single-port data memory with combinational read.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int WIDTH     = DMEM_WIDTH,
    parameter int MEM_DEPTH = DMEM_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req_valid,
    input  logic             p0_req_we,
    input  logic [WIDTH-1:0] p0_req_addr,
    input  logic [WIDTH-1:0] p0_req_wdata,
    output logic             p0_req_ready,
    output logic             p0_rsp_valid,
    output logic [WIDTH-1:0] p0_rsp_rdata,
    output logic             p0_rsp_err,
    input  logic             p0_rsp_ready,
    input  logic             p1_req_valid,
    input  logic             p1_req_we,
    input  logic [WIDTH-1:0] p1_req_addr,
    input  logic [WIDTH-1:0] p1_req_wdata,
    output logic             p1_req_ready,
    output logic             p1_rsp_valid,
    output logic [WIDTH-1:0] p1_rsp_rdata,
    output logic             p1_rsp_err,
    input  logic             p1_rsp_ready,
    output logic             mem_write_read,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_read_data
);

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(MEM_DEPTH);

    logic             elig0_s, elig1_s;
    logic             grant0_s, grant1_s, grant_any_s;
    logic             sel_s, sel_we_s, in_range_s;
    logic [WIDTH-1:0] sel_addr_s, sel_wdata_s;
    logic [WIDTH-1:0] cap_rdata_s;
    logic             cap_err_s;
    logic             last_grant_q, last_grant_d;

    // Grant selection; nothing is granted while reset is held low.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset) begin
            case ({elig1_s, elig0_s})
                2'b01:   grant0_s = 1'b1;
                2'b10:   grant1_s = 1'b1;
                2'b11: begin
                    if (last_grant_q == PORT_CORE) begin
                        grant1_s = 1'b1;
                    end else begin
                        grant0_s = 1'b1;
                    end
                end
                default: begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            endcase
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign grant_any_s  = grant0_s || grant1_s;
    assign sel_s        = grant1_s ? PORT_DBG : PORT_CORE;
    assign sel_we_s     = (sel_s == PORT_DBG) ? p1_req_we    : p0_req_we;
    assign sel_addr_s   = (sel_s == PORT_DBG) ? p1_req_addr  : p0_req_addr;
    assign sel_wdata_s  = (sel_s == PORT_DBG) ? p1_req_wdata : p0_req_wdata;
    assign in_range_s   = (sel_addr_s < DEPTH_W);
    assign p0_req_ready = grant0_s;
    assign p1_req_ready = grant1_s;

    // Memory drive and response capture values for the granted request.
    always_comb begin
        mem_write_read = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        cap_rdata_s    = '0;
        cap_err_s      = 1'b0;
        last_grant_d   = last_grant_q;
        if (grant_any_s) begin
            mem_write_read = sel_we_s && in_range_s;
            mem_address    = sel_addr_s;
            mem_write_data = sel_wdata_s;
            cap_rdata_s    = (!sel_we_s && in_range_s) ? mem_read_data : '0;
            cap_err_s      = !in_range_s;
            last_grant_d   = sel_s;
        end else begin
            last_grant_d   = last_grant_q;
        end
    end

    // Round-robin history; resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= PORT_DBG;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    dmem_rsp_slot #(.WIDTH(WIDTH)) u_slot_core (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (p0_req_valid),
        .rsp_ready_i (p0_rsp_ready),
        .grant_i     (grant0_s),
        .cap_rdata_i (cap_rdata_s),
        .cap_err_i   (cap_err_s),
        .eligible_o  (elig0_s),
        .rsp_valid_o (p0_rsp_valid),
        .rsp_rdata_o (p0_rsp_rdata),
        .rsp_err_o   (p0_rsp_err)
    );

    dmem_rsp_slot #(.WIDTH(WIDTH)) u_slot_dbg (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (p1_req_valid),
        .rsp_ready_i (p1_rsp_ready),
        .grant_i     (grant1_s),
        .cap_rdata_i (cap_rdata_s),
        .cap_err_i   (cap_err_s),
        .eligible_o  (elig1_s),
        .rsp_valid_o (p1_rsp_valid),
        .rsp_rdata_o (p1_rsp_rdata),
        .rsp_err_o   (p1_rsp_err)
    );

endmodule : data_mem_arbiter

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios followed by
// random traffic, checked against a queue/array reference model.
module tb_data_mem_arbiter;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req_valid, p0_req_we, p0_req_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_ready;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
    logic        p1_req_valid, p1_req_we, p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_ready;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
    logic        mem_write_read;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];
    rsp_t        q0[$];
    rsp_t        q1[$];
    logic        last_port;
    logic        acc0, acc1;
    int          vectors    = 0;
    int          miscompares = 0;

    data_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err), .p0_rsp_ready(p0_rsp_ready),
        .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err), .p1_rsp_ready(p1_rsp_ready),
        .mem_write_read(mem_write_read), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, combinational read, junk when out of range.
    assign mem_read_data = (mem_address < 32'd256) ? tb_mem[mem_address[7:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (mem_write_read && (mem_address < 32'd256)) tb_mem[mem_address[7:0]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic mon_port(input int p, input logic v, input logic rdy,
                            input logic [31:0] rd, input logic e);
        rsp_t exp_r;
        int   n;
        n = (p == 0) ? q0.size() : q1.size();
        chk($sformatf("p%0d_rsp_valid", p), {31'd0, v}, {31'd0, (n != 0)});
        if (!v) begin
            chk($sformatf("p%0d_idle_rdata", p), rd, 32'd0);
            chk($sformatf("p%0d_idle_err", p), {31'd0, e}, 32'd0);
        end else if (rdy && n != 0) begin
            exp_r = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("p%0d_rsp_rdata", p), rd, exp_r.rdata);
            chk($sformatf("p%0d_rsp_err", p), {31'd0, e}, {31'd0, exp_r.err});
        end
    endtask

    // Monitor: responses are consumed at the coming posedge when valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            mon_port(0, p0_rsp_valid, p0_rsp_ready, p0_rsp_rdata, p0_rsp_err);
            mon_port(1, p1_rsp_valid, p1_rsp_ready, p1_rsp_rdata, p1_rsp_err);
        end
    end

    // One cycle of stimulus; the model decides the grant and queues the response.
    task automatic run_cycle(input logic v0, input logic we0, input logic [31:0] a0,
                             input logic [31:0] d0, input logic rr0,
                             input logic v1, input logic we1, input logic [31:0] a1,
                             input logic [31:0] d1, input logic rr1);
        logic        e0, e1, g0, g1, we, inr;
        logic [31:0] a, d;
        rsp_t        r;
        @(negedge clk);
        p0_req_valid = v0; p0_req_we = we0; p0_req_addr = a0; p0_req_wdata = d0; p0_rsp_ready = rr0;
        p1_req_valid = v1; p1_req_we = we1; p1_req_addr = a1; p1_req_wdata = d1; p1_rsp_ready = rr1;
        #4;
        e0 = v0 && (q0.size() == 0);
        e1 = v1 && (q1.size() == 0);
        g0 = e0 && (!e1 || last_port == 1'b1);
        g1 = e1 && !g0;
        chk("p0_req_ready", {31'd0, p0_req_ready}, {31'd0, g0});
        chk("p1_req_ready", {31'd0, p1_req_ready}, {31'd0, g1});
        we = g1 ? we1 : we0;
        a  = g1 ? a1 : a0;
        d  = g1 ? d1 : d0;
        inr = (a < 32'd256);
        if (g0 || g1) begin
            chk("mem_write_read", {31'd0, mem_write_read}, {31'd0, (we && inr)});
            chk("mem_address", mem_address, a);
            chk("mem_write_data", mem_write_data, d);
            r.err   = !inr;
            r.rdata = (!we && inr) ? ref_mem[a[7:0]] : 32'd0;
            if (we && inr) ref_mem[a[7:0]] = d;
            if (g0) q0.push_back(r); else q1.push_back(r);
            last_port = g1;
        end else begin
            chk("idle_mem_write_read", {31'd0, mem_write_read}, 32'd0);
            chk("idle_mem_address", mem_address, 32'd0);
        end
        acc0 = g0;
        acc1 = g1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'd256 + 32'($urandom_range(0, 1000));
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd255;
            3:       return $urandom;
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        v0_r, we0_r, v1_r, we1_r;
        logic [31:0] a0_r, d0_r, a1_r, d1_r;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        last_port = 1'b1;
        reset = 1'b0;
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'd5; p0_req_wdata = 32'h1; p0_rsp_ready = 1'b0;
        p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'd6; p1_req_wdata = 32'h0; p1_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        chk("rst_p0_req_ready", {31'd0, p0_req_ready}, 32'd0);
        chk("rst_p1_req_ready", {31'd0, p1_req_ready}, 32'd0);
        chk("rst_mem_write_read", {31'd0, mem_write_read}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;

        // Tie: both request every cycle, grants alternate starting with p0.
        for (int i = 0; i < 6; i++)
            run_cycle(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0, 32'd2, 32'd0, 1'b1);
        // Write then read back on p0.
        run_cycle(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        run_cycle(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        // Backpressure on p1: p0 takes every grant until p1 consumes.
        run_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd7, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_cycle(1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b1, 1'b0, 32'd9, 32'd0, 1'b0);
        run_cycle(1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b1, 1'b0, 32'd9, 32'd0, 1'b1);
        idle(1);
        // Read-after-write across ports in consecutive cycles.
        run_cycle(1'b1, 1'b1, 32'd10, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        run_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd10, 32'd0, 1'b1);
        // Out-of-range accesses; address 256 must not alias onto word 0.
        run_cycle(1'b1, 1'b1, 32'd256, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        run_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        run_cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(1);

        // Random traffic with requests held until accepted.
        v0_r = 1'b0; v1_r = 1'b0; we0_r = 1'b0; we1_r = 1'b0;
        a0_r = 32'd0; a1_r = 32'd0; d0_r = 32'd0; d1_r = 32'd0;
        acc0 = 1'b0; acc1 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!v0_r || acc0) begin
                v0_r = ($urandom_range(0, 3) != 0); we0_r = 1'($urandom_range(0, 1));
                a0_r = rand_addr(); d0_r = $urandom;
            end
            if (!v1_r || acc1) begin
                v1_r = ($urandom_range(0, 3) != 0); we1_r = 1'($urandom_range(0, 1));
                a1_r = rand_addr(); d1_r = $urandom;
            end
            run_cycle(v0_r, we0_r, a0_r, d0_r, ($urandom_range(0, 3) != 0),
                      v1_r, we1_r, a1_r, d1_r, ($urandom_range(0, 3) != 0));
        end
        idle(2);

        // Reset pulled low in the middle of a granted write to addr 3.
        run_cycle(1'b1, 1'b1, 32'd3, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'd3; p0_req_wdata = 32'hAAAA_5555;
        p1_req_valid = 1'b0; p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
        #2;
        chk("pre_rst_p0_req_ready", {31'd0, p0_req_ready}, 32'd1);
        chk("pre_rst_mem_write_read", {31'd0, mem_write_read}, 32'd1);
        reset = 1'b0;
        q0.delete(); q1.delete();
        last_port = 1'b1;
        #1;
        chk("mid_rst_mem_write_read", {31'd0, mem_write_read}, 32'd0);
        chk("mid_rst_p0_req_ready", {31'd0, p0_req_ready}, 32'd0);
        chk("mid_rst_p0_rsp_valid", {31'd0, p0_rsp_valid}, 32'd0);
        chk("mid_rst_p1_rsp_valid", {31'd0, p1_rsp_valid}, 32'd0);
        @(negedge clk);
        p0_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_cycle(1'b1, 1'b0, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_data_mem_arbiter
